// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
//
// Contents:
//   rx_state_t            - receiver frame-tracking states
//   DEFAULT_COUNT_WIDTH   - width of the bit-period counter
//   DEFAULT_COUNT_MAX     - bit period minus one, in clock cycles (300 MHz / 115200)
//   DEFAULT_HALF_MAX      - start-bit mid-point count (DEFAULT_COUNT_MAX / 2)
// Both ends of the link take their period from here so they always agree.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int               DEFAULT_COUNT_WIDTH = 12;
  localparam logic [11:0]      DEFAULT_COUNT_MAX   = 12'd2603;
  localparam logic [11:0]      DEFAULT_HALF_MAX    = 12'd1301;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
//
// Ports:
//   CLK - system clock
//   RST - asynchronous active-high reset; both flops reset to 1 (line idle)
//   d   - asynchronous input
//   q   - synchronised output, two cycles behind d
module sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  // Reset to 1 so that leaving reset never looks like a falling start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
//
// Ports:
//   CLK       - system clock
//   RST       - asynchronous active-high reset (abandons any frame in flight)
//   in        - serial line, idle high, asynchronous to CLK
//   out[7:0]  - received byte, stable while valid=1 and not consumed
//   valid     - holding register full
//   ready     - consumer takes the byte on a cycle where valid && ready
//   frame_err - one-cycle pulse: stop bit sampled low
//   overrun   - one-cycle pulse: byte completed while the holding register was full
//
// HALF_MAX must be strictly less than COUNT_MAX.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int                     COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter logic [COUNT_WIDTH-1:0] COUNT_MAX   = COUNT_WIDTH'(DEFAULT_COUNT_MAX),
  parameter logic [COUNT_WIDTH-1:0] HALF_MAX    = COUNT_WIDTH'(DEFAULT_HALF_MAX)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  logic rx_s;

  sync2 u_sync2 (
    .CLK (CLK),
    .RST (RST),
    .d   (in),
    .q   (rx_s)
  );

  rx_state_t              state_reg,   state_next;
  logic [COUNT_WIDTH-1:0] count_reg,   count_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [7:0]             shift_reg,   shift_next;
  logic                   byte_done;   // stop bit sampled high this cycle
  logic                   stop_bad;    // stop bit sampled low this cycle

  logic [7:0] out_reg;
  logic       valid_reg;
  logic       frame_err_reg;
  logic       overrun_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_done    = 1'b0;
    stop_bad     = 1'b0;

    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (!rx_s) state_next = START;
      end

      // Re-check the line half a bit later so a short low glitch is ignored.
      START: begin
        if (count_reg == HALF_MAX) begin
          count_next   = '0;
          bit_idx_next = 3'd0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end

      // From the start-bit midpoint, every full period lands mid-bit.
      DATA: begin
        if (count_reg == COUNT_MAX) begin
          count_next             = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end

      // Leaving mid-stop-bit lets a back-to-back start edge be caught on time.
      STOP: begin
        if (count_reg == COUNT_MAX) begin
          count_next = '0;
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end

      // A line held low (break) must not be decoded as a stream of 0x00 frames.
      BREAK: begin
        count_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Holding register. A delivery on the same cycle the old byte is consumed
  // replaces it without dropping valid; otherwise a full register drops the
  // new byte and flags overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_reg       <= 8'd0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= 1'b0;
      if (byte_done) begin
        if (!valid_reg || ready) begin
          out_reg   <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out       = out_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
